// File: rtl/sd_clkdiv_pkg.sv
// Shared types and default sizing for the SD clock divider.
//   sd_clk_state_e : controller state (STOPPED, RUN, INIT)
//   DEFAULT_*      : default parameter values for the divider blocks
package sd_clkdiv_pkg;

  localparam int unsigned DEFAULT_DIV_W       = 8;
  localparam int unsigned DEFAULT_INIT_CYCLES = 80;
  localparam int unsigned DEFAULT_INIT_CNT_W  = 16;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    INIT    = 2'd2
  } sd_clk_state_e;

endpackage

// File: rtl/sd_clkdiv_counter.sv
// Half-period counter with boundary detect and the active-divider register.
//   CLK, RST   : clock, synchronous active-high reset
//   run        : count enable; counter is held at 0 while low
//   divider    : requested half-period minus 1, sampled at boundaries
//   div_active : divider value governing the current half-period
//   boundary_c : combinational, high in the last cycle of a half-period
module sd_clkdiv_counter
  import sd_clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = DEFAULT_DIV_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [DIV_W-1:0] divider,
  output logic [DIV_W-1:0] div_active,
  output logic             boundary_c
);

  logic [DIV_W-1:0] count;

  assign boundary_c = run && (count == div_active);

  // New divider only takes effect at a half-period edge, so phases never get cut short.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count      <= '0;
      div_active <= divider;
    end else if (!run) begin
      count <= '0;
    end else if (boundary_c) begin
      count      <= '0;
      div_active <= divider;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sd_clock_divider_ctrl.sv
// SD card clock generator: even divide of CLK, glitch-free divider changes,
// low-parked stop/start and an automatic power-up burst.
//   CLK, RST    : clock, synchronous active-high reset
//   DIVIDER     : half-period minus 1 (half-period = DIVIDER+1 CLK cycles)
//   CLK_EN      : request a free-running SD_CLK
//   INIT_REQ    : pulse to start a burst of INIT_CYCLES SD_CLK periods
//   SD_CLK      : divided clock (registered)
//   SD_CLK_RISE : high in the first cycle SD_CLK reads 1
//   SD_CLK_FALL : high in the first cycle SD_CLK reads 0 after being 1
//   CLK_RUNNING : state is RUN or INIT
//   INIT_BUSY   : state is INIT
//   INIT_DONE   : pulse coincident with the final FALL of the burst
//   DIV_ACTIVE  : divider value currently in effect
module sd_clock_divider_ctrl
  import sd_clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = DEFAULT_DIV_W,
  parameter int unsigned INIT_CYCLES = DEFAULT_INIT_CYCLES,
  parameter int unsigned INIT_CNT_W  = DEFAULT_INIT_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIVIDER,
  input  logic             CLK_EN,
  input  logic             INIT_REQ,
  output logic             SD_CLK,
  output logic             SD_CLK_RISE,
  output logic             SD_CLK_FALL,
  output logic             CLK_RUNNING,
  output logic             INIT_BUSY,
  output logic             INIT_DONE,
  output logic [DIV_W-1:0] DIV_ACTIVE
);

  localparam logic [INIT_CNT_W-1:0] LAST_PERIOD = INIT_CNT_W'(INIT_CYCLES - 1);

  sd_clk_state_e         state;
  logic [INIT_CNT_W-1:0] init_cnt;
  logic                  boundary_c;

  sd_clkdiv_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .run        (state != STOPPED),
    .divider    (DIVIDER),
    .div_active (DIV_ACTIVE),
    .boundary_c (boundary_c)
  );

  // Controller FSM, burst period counter and edge strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= STOPPED;
      init_cnt    <= '0;
      SD_CLK      <= 1'b0;
      SD_CLK_RISE <= 1'b0;
      SD_CLK_FALL <= 1'b0;
      CLK_RUNNING <= 1'b0;
      INIT_BUSY   <= 1'b0;
      INIT_DONE   <= 1'b0;
    end else begin
      SD_CLK_RISE <= 1'b0;
      SD_CLK_FALL <= 1'b0;
      INIT_DONE   <= 1'b0;
      case (state)
        STOPPED: begin
          if (INIT_REQ) begin
            state       <= INIT;
            init_cnt    <= '0;
            CLK_RUNNING <= 1'b1;
            INIT_BUSY   <= 1'b1;
          end else if (CLK_EN) begin
            state       <= RUN;
            CLK_RUNNING <= 1'b1;
          end
        end
        RUN: begin
          if (boundary_c) begin
            if (!CLK_EN) begin
              // Stop only at a boundary so the high phase is never shortened.
              state       <= STOPPED;
              CLK_RUNNING <= 1'b0;
              if (SD_CLK) begin
                SD_CLK      <= 1'b0;
                SD_CLK_FALL <= 1'b1;
              end
            end else begin
              SD_CLK      <= ~SD_CLK;
              SD_CLK_RISE <= ~SD_CLK;
              SD_CLK_FALL <= SD_CLK;
            end
          end
        end
        INIT: begin
          if (boundary_c) begin
            SD_CLK <= ~SD_CLK;
            if (SD_CLK) begin
              SD_CLK_FALL <= 1'b1;
              if (init_cnt == LAST_PERIOD) begin
                INIT_DONE   <= 1'b1;
                INIT_BUSY   <= 1'b0;
                CLK_RUNNING <= CLK_EN;
                state       <= CLK_EN ? RUN : STOPPED;
              end else begin
                init_cnt <= init_cnt + INIT_CNT_W'(1);
              end
            end else begin
              SD_CLK_RISE <= 1'b1;
            end
          end
        end
        default: begin
          state       <= STOPPED;
          SD_CLK      <= 1'b0;
          CLK_RUNNING <= 1'b0;
          INIT_BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_clock_divider_ctrl.sv
// Scoreboard bench for sd_clock_divider_ctrl: a reference model predicts every
// SD_CLK edge (time, level, flags, divider); a monitor pops on each strobe.
module tb_sd_clock_divider_ctrl;

  localparam int unsigned DIV_W       = 8;
  localparam int unsigned INIT_CYCLES = 80;
  localparam int unsigned INIT_CNT_W  = 16;
  localparam int unsigned NEVER       = 32'hFFFF_FFFF;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [DIV_W-1:0] DIVIDER = '0;
  logic             CLK_EN = 1'b0;
  logic             INIT_REQ = 1'b0;
  logic             SD_CLK, SD_CLK_RISE, SD_CLK_FALL;
  logic             CLK_RUNNING, INIT_BUSY, INIT_DONE;
  logic [DIV_W-1:0] DIV_ACTIVE;

  sd_clock_divider_ctrl #(
    .DIV_W       (DIV_W),
    .INIT_CYCLES (INIT_CYCLES),
    .INIT_CNT_W  (INIT_CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .DIVIDER     (DIVIDER),
    .CLK_EN      (CLK_EN),
    .INIT_REQ    (INIT_REQ),
    .SD_CLK      (SD_CLK),
    .SD_CLK_RISE (SD_CLK_RISE),
    .SD_CLK_FALL (SD_CLK_FALL),
    .CLK_RUNNING (CLK_RUNNING),
    .INIT_BUSY   (INIT_BUSY),
    .INIT_DONE   (INIT_DONE),
    .DIV_ACTIVE  (DIV_ACTIVE)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned      t;
    logic             lvl;
    logic             done;
    logic             run;
    logic             busy;
    logic [DIV_W-1:0] div;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;

  int n_total = 0;
  int n_pass  = 0;
  int overlap = 0;
  int stray_done = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int unsigned t, input bit lvl, input bit done, input bit run,
                      input bit busy, input int unsigned div);
    ev_t ev;
    ev.t = t; ev.lvl = lvl; ev.done = done; ev.run = run; ev.busy = busy; ev.div = DIV_W'(div);
    exp_q.push_back(ev);
  endtask

  // Reference model: walks half-periods from the start edge e. Each half-period
  // lasts (divider in force at its start)+1 cycles; DIVIDER is d0 before tc and
  // d1 from tc on; CLK_EN is high before ts; RST at tr kills everything from tr.
  task automatic gen(input int unsigned e, input bit init, input int unsigned d0, input int unsigned d1,
                     input int unsigned tc, input int unsigned ts, input int unsigned tr,
                     output int unsigned stop_b);
    int unsigned t      = e;
    int unsigned active = d0;
    int unsigned left   = init ? 2 * INIT_CYCLES : 0;
    int unsigned b, div_b;
    bit lvl = 1'b0;
    bit en;
    bit going = 1'b1;
    int guard = 0;
    stop_b = e;
    while (going && guard < 4000) begin
      b     = t + active + 1;
      div_b = (b >= tc) ? d1 : d0;
      en    = (b < ts);
      if (b >= tr) begin
        stop_b = tr;
        going  = 1'b0;
      end else if (left > 0) begin
        lvl = ~lvl;
        left--;
        push(b, lvl, left == 0, (left != 0) || en, left != 0, div_b);
        if (left == 0 && !en) begin
          stop_b = b;
          going  = 1'b0;
        end
      end else if (!en) begin
        if (lvl) push(b, 1'b0, 1'b0, 1'b0, 1'b0, div_b);
        stop_b = b;
        going  = 1'b0;
      end else begin
        lvl = ~lvl;
        push(b, lvl, 1'b0, 1'b1, 1'b0, div_b);
      end
      active = div_b;
      t      = b;
      guard++;
    end
  endtask

  // Monitor: every strobe must match the next predicted edge.
  always @(negedge CLK) begin
    if (SD_CLK_RISE === 1'b1 && SD_CLK_FALL === 1'b1) overlap++;
    if (INIT_DONE === 1'b1 && SD_CLK_FALL !== 1'b1) stray_done++;
    if (SD_CLK_RISE === 1'b1 || SD_CLK_FALL === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1'b0, 64'({SD_CLK_RISE, SD_CLK_FALL}), 64'(0));
      end else begin
        mon_ev = exp_q.pop_front();
        check("edge_time", cyc == mon_ev.t, 64'(cyc), 64'(mon_ev.t));
        check("edge_kind", {SD_CLK, SD_CLK_RISE, SD_CLK_FALL} === {mon_ev.lvl, mon_ev.lvl, ~mon_ev.lvl},
              64'({SD_CLK, SD_CLK_RISE, SD_CLK_FALL}), 64'({mon_ev.lvl, mon_ev.lvl, ~mon_ev.lvl}));
        check("edge_flags", {INIT_DONE, CLK_RUNNING, INIT_BUSY} === {mon_ev.done, mon_ev.run, mon_ev.busy},
              64'({INIT_DONE, CLK_RUNNING, INIT_BUSY}), 64'({mon_ev.done, mon_ev.run, mon_ev.busy}));
        check("div_active", DIV_ACTIVE === mon_ev.div, 64'(DIV_ACTIVE), 64'(mon_ev.div));
      end
    end
  end

  task automatic scenario(input bit init, input int unsigned d0, input int unsigned d1,
                          input int unsigned tc_rel, input int unsigned ts_rel,
                          input bit abort, input int unsigned tr_rel);
    int unsigned e, tc, ts, tr, stop_b, last;
    RST = 1'b1; DIVIDER = DIV_W'(d0); CLK_EN = 1'b0; INIT_REQ = 1'b0;
    @(negedge CLK);
    check("rst_outputs", {SD_CLK, SD_CLK_RISE, SD_CLK_FALL, CLK_RUNNING, INIT_BUSY, INIT_DONE} === 6'b0,
          64'({SD_CLK, SD_CLK_RISE, SD_CLK_FALL, CLK_RUNNING, INIT_BUSY, INIT_DONE}), 64'(0));
    check("rst_div_active", DIV_ACTIVE === DIV_W'(d0), 64'(DIV_ACTIVE), 64'(d0));
    RST = 1'b0;
    e  = cyc + 1;
    tc = e + tc_rel;
    ts = e + ts_rel;
    tr = abort ? e + tr_rel : NEVER;
    gen(e, init, d0, d1, tc, ts, tr, stop_b);
    last = stop_b + 4;
    for (int unsigned k = e; k <= last; k++) begin
      DIVIDER  = (k >= tc) ? DIV_W'(d1) : DIV_W'(d0);
      CLK_EN   = (k < ts);
      INIT_REQ = (init && k == e) || (k == e + 1);
      RST      = abort && (k == tr);
      @(negedge CLK);
      if (abort && k == tr)
        check("abort_outputs", {SD_CLK, SD_CLK_RISE, SD_CLK_FALL, CLK_RUNNING, INIT_BUSY, INIT_DONE} === 6'b0,
              64'({SD_CLK, SD_CLK_RISE, SD_CLK_FALL, CLK_RUNNING, INIT_BUSY, INIT_DONE}), 64'(0));
    end
    CLK_EN = 1'b0; INIT_REQ = 1'b0; RST = 1'b0;
    check("edges_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'(0));
    check("parked_low", {SD_CLK, CLK_RUNNING, INIT_BUSY} === 3'b0,
          64'({SD_CLK, CLK_RUNNING, INIT_BUSY}), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    scenario(1'b0, 3, 3, NEVER, 25, 1'b0, 0);                // steady /8
    scenario(1'b0, 0, 0, NEVER, 10, 1'b0, 0);                // CLK/2
    scenario(1'b0, 3, 1, 6, 30, 1'b0, 0);                    // divider change mid high phase
    scenario(1'b0, 5, 5, NEVER, 7, 1'b0, 0);                 // stop requested just after a rise
    scenario(1'b1, 1, 1, NEVER, 0, 1'b0, 0);                 // burst, then stop
    scenario(1'b1, 1, 1, NEVER, 0, 1'b1, 159);               // reset during period 40
    scenario(1'b1, 1, 1, NEVER, 0, 1'b0, 0);                 // fresh burst counts from 0
    scenario(1'b1, 2, 4, 300, 700, 1'b0, 0);                 // burst with divider change, then run
    scenario(1'b0, 255, 255, NEVER, 300, 1'b0, 0);           // max divider
    repeat (12)
      scenario(1'b0, $urandom_range(0, 6), $urandom_range(0, 6),
               $urandom_range(1, 40), $urandom_range(1, 60), 1'b0, 0);
    repeat (2)
      scenario(1'b1, $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(1, 300), $urandom_range(0, 700), 1'b0, 0);
    check("no_strobe_overlap", overlap == 0, 64'(overlap), 64'(0));
    check("no_stray_init_done", stray_done == 0, 64'(stray_done), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
